apu_i2s_out: RTL and testbench
==============================

Name: apu_i2s_out

Overview:
- Downstream consumer of the APU mixer output.
- Low-pass filters the 6-bit unsigned mixer sample, clocked by the cpu_clock enable strobe.
- Removes the mid-scale offset, producing a 16-bit signed PCM sample once per audio frame.
- Serializes that sample as mono (L=R) standard I2S to the board audio codec.
- Runs entirely in the sysclk domain; all clocks it produces (bclk, lrck) are registered outputs.

Parameters:
- BCLK_HALF, 4: sysclk cycles per bclk half-period; legal range 2..255.
- FILT_SHIFT, 3: IIR coefficient, alpha = 2^-FILT_SHIFT; legal range 1..8.

Ports:
- sysclk  in  1  system clock
- reset  in  1  asynchronous reset, active-high
- cpu_clock  in  1  one-sysclk-wide enable strobe at the APU rate
- sound_in  in  6  unsigned mixer output, 0..63
- enable  in  1  0 forces transmitted samples to 0x0000; the filter keeps running
- bclk  out  1  I2S bit clock
- lrck  out  1  I2S word select; 0 = left, 1 = right
- sdata  out  1  I2S serial data
- sample_strobe  out  1  one-sysclk pulse when a new sample is latched

Behaviour:
- Reset:
  - bclk=0, lrck=0, sdata=0, sample_strobe=0.
  - Filter state y=0, latched sample=0x0000.
  - Divider=0, bit_cnt=0.
  - Reset mid-frame aborts the frame immediately; there is no partial-word completion.
- Filter (in cycles where cpu_clock=1):
  - x = {sound_in, 9'b0}, 15 bits zero-extended, range 0..32256.
  - d = x - y, computed as 17-bit signed.
  - y <= y + (d >>> FILT_SHIFT), arithmetic shift.
  - y is 16-bit unsigned and never leaves 0..32256.
  - Because the shift floors, for rising input y settles up to 2^FILT_SHIFT-1 below x. For falling input y reaches x exactly.
- Conversion: pcm = y - 16384, 16-bit two's complement. Range 0xC000 (-16384) .. 0x3E00 (15872).
- Divider and bit clock:
  - The divider counts 0..BCLK_HALF-1, then wraps and toggles bclk.
  - First bclk rise occurs BCLK_HALF cycles after reset release.
- Bit counter: 6-bit bit_cnt advances on each bclk falling toggle (the cycle bclk goes 1->0), wrapping 63->0.
- Registered outputs, updated in the same cycle as bclk falls:
  - lrck = new bit_cnt[5].
  - sdata = latched_sample[16-k] for k = new bit_cnt[4:0] in 1..16, otherwise 0.
  - Result: MSB appears one bclk after the lrck edge (I2S standard), 16 data bits, then 16 zero pad bits per slot.
  - The codec samples on the bclk rise.
- Sample latch:
  - On the fall where bit_cnt wraps 63->0: latched_sample <= enable ? pcm : 0x0000.
  - sample_strobe=1 for that single cycle.
  - Left and right slots of the frame both transmit this value.
  - Frame length = 128*BCLK_HALF sysclk cycles.
- Simultaneous events:
  - When cpu_clock and the latch coincide, the latch takes the registered pre-update y.
  - A change on enable takes effect only at the next latch; a word is never altered mid-frame.
- sound_in is sampled only when cpu_clock=1; it is ignored at other times.

Decomposition:
- Package apu_audio_pkg:
  - PCM_W=16, SLOT_BITS=32, FRAME_BITS=64, PCM_MIDPOINT=16'd16384.
  - Function to_pcm(y).
- Sub-module apu_i2s_serializer:
  - Contains the divider, bclk/lrck/bit_cnt/sdata logic and sample_strobe.
  - Parallel 16-bit input, latched at the frame wrap.
  - The top level holds the IIR and the enable gating.

Test Plan:
- Reset release, BCLK_HALF=2, no cpu_clock:
  - First bclk rise at cycle 2; bclk period 4 cycles; lrck period 256 cycles.
  - First sample_strobe after 64 falls.
  - sdata carries 0xC000 (bit1=1, bit2=1, rest 0) in both slots.
- sound_in=63, cpu_clock every 12 cycles, enable=1, run 200 strobes:
  - Decoded words settle within 0x3DF9..0x3E00, monotonically rising.
  - L word == R word.
- Step sound_in 63->0 after settling:
  - Decoded words fall monotonically and reach exactly 0xC000.
- enable=0 while sound_in=63 settled:
  - The next latched frame transmits 0x0000; the current frame is unaltered.
  - Re-asserting enable restores ~0x3E00 at the following latch.
- Assert reset mid-right-slot (bit_cnt=40):
  - All outputs go 0 asynchronously.
  - After release, the frame restarts from bit_cnt=0 with sample 0xC000.
- cpu_clock coincident with the latch cycle:
  - The latched word equals pcm of y before that strobe's update (checked against the reference model).

Source files
------------

// File: rtl/apu_audio_pkg.sv
// Shared constants and helpers for the APU audio output path.
package apu_audio_pkg;

    localparam int unsigned PCM_W        = 16;
    localparam int unsigned SLOT_BITS    = 32;
    localparam int unsigned FRAME_BITS   = 64;
    localparam logic [15:0] PCM_MIDPOINT = 16'd16384;

    // Filter state is unsigned 0..32256; centre it so silence sits at -16384.
    function automatic logic [PCM_W-1:0] to_pcm(input logic [15:0] y);
        return y - PCM_MIDPOINT;
    endfunction

endpackage

// File: rtl/apu_i2s_serializer.sv
// Mono I2S transmitter: registered bclk/lrck/sdata, word latched once per 64-bit frame.
module apu_i2s_serializer
    import apu_audio_pkg::*;
#(
    parameter int unsigned BCLK_HALF = 4
) (
    input  logic             sysclk,
    input  logic             reset,
    input  logic [PCM_W-1:0] sample,
    output logic             bclk,
    output logic             lrck,
    output logic             sdata,
    output logic             sample_strobe
);

    localparam int unsigned CNT_W    = $clog2(FRAME_BITS);
    localparam int unsigned SLOT_W   = $clog2(SLOT_BITS);
    localparam logic [7:0]  DIV_LAST = 8'(BCLK_HALF - 1);

    logic [7:0]       div_q, div_d;
    logic             bclk_q, bclk_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             lrck_q, lrck_d;
    logic             sdata_q, sdata_d;
    logic             strobe_q, strobe_d;
    logic [PCM_W-1:0] word_q, word_d;
    logic [SLOT_W-1:0] slot_idx;
    logic [3:0]       bit_sel;

    always_comb begin
        div_d     = div_q + 8'd1;
        bclk_d    = bclk_q;
        bit_cnt_d = bit_cnt_q;
        lrck_d    = lrck_q;
        sdata_d   = sdata_q;
        strobe_d  = 1'b0;
        word_d    = word_q;
        slot_idx  = '0;
        bit_sel   = '0;
        if (div_q == DIV_LAST) begin
            div_d  = 8'd0;
            bclk_d = ~bclk_q;
            // Everything the codec sees changes only on the bclk falling toggle.
            if (bclk_q) begin
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
                lrck_d    = bit_cnt_d[CNT_W-1];
                slot_idx  = bit_cnt_d[SLOT_W-1:0];
                bit_sel   = 4'(PCM_W - 32'(slot_idx));
                if (slot_idx != '0 && 32'(slot_idx) <= PCM_W) begin
                    sdata_d = word_q[bit_sel];
                end else begin
                    sdata_d = 1'b0;
                end
                if (bit_cnt_d == '0) begin
                    word_d   = sample;
                    strobe_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            div_q     <= '0;
            bclk_q    <= 1'b0;
            bit_cnt_q <= '0;
            lrck_q    <= 1'b0;
            sdata_q   <= 1'b0;
            strobe_q  <= 1'b0;
            word_q    <= '0;
        end else begin
            div_q     <= div_d;
            bclk_q    <= bclk_d;
            bit_cnt_q <= bit_cnt_d;
            lrck_q    <= lrck_d;
            sdata_q   <= sdata_d;
            strobe_q  <= strobe_d;
            word_q    <= word_d;
        end
    end

    assign bclk          = bclk_q;
    assign lrck          = lrck_q;
    assign sdata         = sdata_q;
    assign sample_strobe = strobe_q;

endmodule

// File: rtl/apu_i2s_out.sv
// APU mixer to I2S: one-pole IIR low-pass on the mixer sample, offset removal, mono I2S out.
module apu_i2s_out
    import apu_audio_pkg::*;
#(
    parameter int unsigned BCLK_HALF  = 4,
    parameter int unsigned FILT_SHIFT = 3
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       cpu_clock,
    input  logic [5:0] sound_in,
    input  logic       enable,
    output logic       bclk,
    output logic       lrck,
    output logic       sdata,
    output logic       sample_strobe
);

    logic [15:0]        y_q, y_d;
    logic [14:0]        x;
    logic signed [16:0] diff;
    logic signed [16:0] step;
    logic signed [16:0] sum;
    logic [PCM_W-1:0]   pcm_gated;

    always_comb begin
        x    = {sound_in, 9'b0};
        diff = $signed({2'b00, x}) - $signed({1'b0, y_q});
        // Arithmetic shift floors, so rising input settles just below x, falling reaches it.
        step = diff >>> FILT_SHIFT;
        sum  = $signed({1'b0, y_q}) + step;
        y_d  = cpu_clock ? sum[15:0] : y_q;
        // Uses the registered y, so a coincident strobe latches the pre-update value.
        pcm_gated = enable ? to_pcm(y_q) : '0;
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            y_q <= '0;
        end else begin
            y_q <= y_d;
        end
    end

    apu_i2s_serializer #(
        .BCLK_HALF(BCLK_HALF)
    ) u_serializer (
        .sysclk       (sysclk),
        .reset        (reset),
        .sample       (pcm_gated),
        .bclk         (bclk),
        .lrck         (lrck),
        .sdata        (sdata),
        .sample_strobe(sample_strobe)
    );

endmodule

// File: tb/tb_apu_i2s_out.sv
// Directed bench for apu_i2s_out: I2S timing, filter settling, enable gating, reset, coincidence.
module tb_apu_i2s_out;

    localparam int unsigned BH = 2;
    localparam int unsigned FS = 3;

    logic       sysclk    = 1'b0;
    logic       reset     = 1'b1;
    logic       cpu_clock = 1'b0;
    logic       enable    = 1'b1;
    logic [5:0] sound_in  = 6'd0;
    logic       bclk, lrck, sdata, sample_strobe;

    int tests   = 0;
    int fails   = 0;
    int model_y = 0;

    logic [15:0] lwords[$];
    logic [15:0] rwords[$];
    logic        prev_bclk = 1'b0;
    logic        prev_lrck = 1'b0;
    int          rise_idx  = 0;
    logic [15:0] shreg     = '0;

    apu_i2s_out #(
        .BCLK_HALF (BH),
        .FILT_SHIFT(FS)
    ) dut (
        .sysclk       (sysclk),
        .reset        (reset),
        .cpu_clock    (cpu_clock),
        .sound_in     (sound_in),
        .enable       (enable),
        .bclk         (bclk),
        .lrck         (lrck),
        .sdata        (sdata),
        .sample_strobe(sample_strobe)
    );

    always #5 sysclk = ~sysclk;

    // Receiver: bits 1..16 after each lrck edge form the word, MSB first.
    always @(negedge sysclk) begin
        prev_bclk <= bclk;
        prev_lrck <= lrck;
        if (reset) begin
            rise_idx <= 0;
        end else if (lrck != prev_lrck) begin
            rise_idx <= 0;
        end else if (bclk && !prev_bclk) begin
            if (rise_idx >= 1 && rise_idx <= 16) begin
                shreg <= {shreg[14:0], sdata};
                if (rise_idx == 16) begin
                    if (lrck) rwords.push_back({shreg[14:0], sdata});
                    else      lwords.push_back({shreg[14:0], sdata});
                end
            end
            rise_idx <= rise_idx + 1;
        end
    end

    function automatic int filt(input int y, input logic [5:0] s);
        int d;
        d = (int'(s) << 9) - y;
        return y + (d >>> FS);
    endfunction

    function automatic logic [15:0] pcm(input int y);
        return 16'(y - 16384);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cpu_pulse();
        cpu_clock = 1'b1;
        model_y   = filt(model_y, sound_in);
        @(negedge sysclk);
        cpu_clock = 1'b0;
    endtask

    task automatic run_cpu(input int n);
        for (int i = 0; i < n; i++) begin
            cpu_pulse();
            repeat (11) @(negedge sysclk);
        end
    endtask

    task automatic wait_strobe(input string tag);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 600 && !got; i++) begin
            @(negedge sysclk);
            if (sample_strobe) got = 1'b1;
        end
        check(tag, 32'(got), 32'd1);
    endtask

    task automatic wait_words(input int n, input string tag);
        int i;
        i = 0;
        while (rwords.size() < n && i < 3000) begin
            @(negedge sysclk);
            i++;
        end
        check(tag, 32'(rwords.size() >= n), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_rise, second_rise, lr_rise, lr_fall, strobe_at;
        int start, bad_mono, bad_lr, idx, pre;
        logic last_b, last_l;
        logic [15:0] last, p;

        // Reset state
        repeat (3) @(negedge sysclk);
        check("rst_bclk", 32'(bclk), 32'd0);
        check("rst_lrck", 32'(lrck), 32'd0);
        check("rst_sdata", 32'(sdata), 32'd0);
        check("rst_strobe", 32'(sample_strobe), 32'd0);

        // Timing after release, no cpu_clock
        reset = 1'b0;
        first_rise = -1; second_rise = -1; lr_rise = -1; lr_fall = -1; strobe_at = -1;
        last_b = 1'b0; last_l = 1'b0;
        for (int c = 1; c <= 300; c++) begin
            @(negedge sysclk);
            if (bclk && !last_b) begin
                if (first_rise < 0) first_rise = c;
                else if (second_rise < 0) second_rise = c;
            end
            if (lrck && !last_l && lr_rise < 0) lr_rise = c;
            if (!lrck && last_l && lr_fall < 0) lr_fall = c;
            if (sample_strobe && strobe_at < 0) strobe_at = c;
            last_b = bclk;
            last_l = lrck;
        end
        check("first_bclk_rise", first_rise, 2);
        check("second_bclk_rise", second_rise, 6);
        check("lrck_rise", lr_rise, 128);
        check("lrck_fall", lr_fall, 256);
        check("first_strobe", strobe_at, 256);
        wait_words(2, "p1_words");
        check("p1_l0", lwords[0], 16'h0000);
        check("p1_r0", rwords[0], 16'h0000);
        check("p1_l1", lwords[1], 16'hC000);
        check("p1_r1", rwords[1], 16'hC000);

        // Rising step to full scale
        sound_in = 6'd63;
        start = rwords.size();
        run_cpu(200);
        wait_words(rwords.size() + 2, "p2_words");
        last = rwords[rwords.size() - 1];
        check("p2_final_model", last, pcm(model_y));
        check("p2_final_range", 32'(last >= 16'h3DF9 && last <= 16'h3E00), 32'd1);
        bad_mono = 0; bad_lr = 0;
        for (int i = start; i < rwords.size(); i++) begin
            if ($signed(rwords[i]) < $signed(rwords[i-1])) bad_mono++;
            if (lwords[i] !== rwords[i]) bad_lr++;
        end
        check("p2_monotonic", bad_mono, 0);
        check("p2_l_eq_r", bad_lr, 0);

        // Falling step to zero
        sound_in = 6'd0;
        start = rwords.size();
        run_cpu(200);
        wait_words(rwords.size() + 2, "p3_words");
        check("p3_final", rwords[rwords.size() - 1], 16'hC000);
        check("p3_final_l", lwords[lwords.size() - 1], 16'hC000);
        bad_mono = 0; bad_lr = 0;
        for (int i = start; i < rwords.size(); i++) begin
            if ($signed(rwords[i]) > $signed(rwords[i-1])) bad_mono++;
            if (lwords[i] !== rwords[i]) bad_lr++;
        end
        check("p3_monotonic", bad_mono, 0);
        check("p3_l_eq_r", bad_lr, 0);

        // Enable gating applies only at the next latch
        sound_in = 6'd63;
        run_cpu(200);
        wait_strobe("p4_sync0");
        idx = lwords.size();
        p = pcm(model_y);
        repeat (40) @(negedge sysclk);
        enable = 1'b0;
        wait_strobe("p4_sync1");
        repeat (40) @(negedge sysclk);
        enable = 1'b1;
        wait_strobe("p4_sync2");
        wait_words(idx + 3, "p4_words");
        check("p4_cur_l", lwords[idx], p);
        check("p4_cur_r", rwords[idx], p);
        check("p4_cur_range", 32'(lwords[idx] >= 16'h3DF9 && lwords[idx] <= 16'h3E00), 32'd1);
        check("p4_off_l", lwords[idx+1], 16'h0000);
        check("p4_off_r", rwords[idx+1], 16'h0000);
        check("p4_on_l", lwords[idx+2], p);
        check("p4_on_r", rwords[idx+2], p);

        // Reset in the right slot at bit_cnt=40
        wait_strobe("p5_sync");
        repeat (162) @(negedge sysclk);
        check("p5_pre_lrck", 32'(lrck), 32'd1);
        reset = 1'b1;
        #1;
        check("p5_async_bclk", 32'(bclk), 32'd0);
        check("p5_async_lrck", 32'(lrck), 32'd0);
        check("p5_async_sdata", 32'(sdata), 32'd0);
        check("p5_async_strobe", 32'(sample_strobe), 32'd0);
        @(negedge sysclk);
        lwords.delete();
        rwords.delete();
        model_y = 0;
        repeat (2) @(negedge sysclk);
        reset = 1'b0;
        strobe_at = -1;
        for (int c = 1; c <= 600 && strobe_at < 0; c++) begin
            @(negedge sysclk);
            if (sample_strobe) strobe_at = c;
        end
        check("p5_restart_strobe", strobe_at, 256);
        wait_words(2, "p5_words");
        check("p5_l0", lwords[0], 16'h0000);
        check("p5_l1", lwords[1], 16'hC000);
        check("p5_r1", rwords[1], 16'hC000);

        // cpu_clock on the latch cycle
        run_cpu(20);
        wait_strobe("p6_sync");
        repeat (255) @(negedge sysclk);
        pre = model_y;
        idx = lwords.size();
        cpu_pulse();
        check("p6_coincide", 32'(sample_strobe), 32'd1);
        wait_words(idx + 1, "p6_words");
        check("p6_pre_l", lwords[idx], pcm(pre));
        check("p6_pre_r", rwords[idx], pcm(pre));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
